// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable clock divider with glitch-free divisor update
// Per-channel rising-edge tick outputs exist only when CLKDIV_TICK_EN is defined.
module clkdiv_multi #(
   parameter int NCH        = 4,
   parameter int WIDTH      = 32,
   parameter int DEFAULT_HP = 50000
) (
   input  logic             clksrc,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic [3:0]       wr_ch,
   input  logic [WIDTH-1:0] wr_hp,
   output logic [NCH-1:0]   clk,
   output logic [NCH-1:0]   tick,
   output logic             clklk
);
   localparam logic [WIDTH-1:0] HP_RST   = WIDTH'(DEFAULT_HP);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic             LOCK_RST = (DEFAULT_HP == 0);

   logic [WIDTH-1:0] hp_act_q  [NCH];
   logic [WIDTH-1:0] hp_act_d  [NCH];
   logic [WIDTH-1:0] count_q   [NCH];
   logic [WIDTH-1:0] count_d   [NCH];
   logic [WIDTH-1:0] pend_hp_q [NCH];
   logic [WIDTH-1:0] pend_hp_d [NCH];
   logic [NCH-1:0]   pend_v_q, pend_v_d;
   logic [NCH-1:0]   locked_q, locked_d;
   logic [NCH-1:0]   clk_q, clk_d;
   logic             clklk_q;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         hp_act_d[i]  = hp_act_q[i];
         count_d[i]   = count_q[i];
         pend_hp_d[i] = pend_hp_q[i];
         pend_v_d[i]  = pend_v_q[i];
         locked_d[i]  = locked_q[i];
         clk_d[i]     = clk_q[i];
         if (hp_act_q[i] == '0) begin
            count_d[i]  = '0;
            clk_d[i]    = 1'b0;
            locked_d[i] = 1'b1;
            if (pend_v_q[i]) begin
               hp_act_d[i] = pend_hp_q[i];
               pend_v_d[i] = 1'b0;
               locked_d[i] = (pend_hp_q[i] == '0);
            end
         end else if (count_q[i] == hp_act_q[i] - ONE) begin
            count_d[i]  = '0;
            clk_d[i]    = ~clk_q[i];
            locked_d[i] = 1'b1;
            // Divisor swaps only at terminal count so the current half-period completes intact.
            if (pend_v_q[i]) begin
               hp_act_d[i] = pend_hp_q[i];
               pend_v_d[i] = 1'b0;
               locked_d[i] = 1'b0;
               if (pend_hp_q[i] == '0) begin
                  clk_d[i]    = 1'b0;
                  locked_d[i] = 1'b1;
               end
            end
         end else begin
            count_d[i] = count_q[i] + ONE;
         end
         // A write on the terminal edge must not be consumed by that same terminal.
         if (wr_en && (wr_ch == 4'(i))) begin
            pend_hp_d[i] = wr_hp;
            pend_v_d[i]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clksrc) begin
      if (!rstn) begin
         for (int i = 0; i < NCH; i++) begin
            hp_act_q[i]  <= HP_RST;
            count_q[i]   <= '0;
            pend_hp_q[i] <= '0;
         end
         pend_v_q <= '0;
         locked_q <= {NCH{LOCK_RST}};
         clk_q    <= '0;
         clklk_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            hp_act_q[i]  <= hp_act_d[i];
            count_q[i]   <= count_d[i];
            pend_hp_q[i] <= pend_hp_d[i];
         end
         pend_v_q <= pend_v_d;
         locked_q <= locked_d;
         clk_q    <= clk_d;
         clklk_q  <= &(locked_q & ~pend_v_q);
      end
   end

`ifdef CLKDIV_TICK_EN
   logic [NCH-1:0] tick_q;

   always_ff @(posedge clksrc) begin
      if (!rstn) begin
         tick_q <= '0;
      end else begin
         tick_q <= clk_d & ~clk_q;
      end
   end

   assign tick = tick_q;
`else
   assign tick = '0;
`endif

   assign clk   = clk_q;
   assign clklk = clklk_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - self-checking bench for clkdiv_multi against an absolute-time event model
module tb_clkdiv_multi;
   localparam int NCH   = 2;
   localparam int WIDTH = 8;
   localparam int DHP   = 4;

`ifdef CLKDIV_TICK_EN
   localparam bit TICK_ON = 1'b1;
`else
   localparam bit TICK_ON = 1'b0;
`endif

   logic             clksrc = 1'b0;
   logic             rstn   = 1'b0;
   logic             wr_en  = 1'b0;
   logic [3:0]       wr_ch  = '0;
   logic [WIDTH-1:0] wr_hp  = '0;
   logic [NCH-1:0]   clk;
   logic [NCH-1:0]   tick;
   logic             clklk;

   int checks   = 0;
   int failures = 0;

   // Model: each channel knows the absolute edge number of its next toggle.
   int             n;
   int             hp  [NCH];
   int             nxt [NCH];
   int             php [NCH];
   bit             pv  [NCH];
   bit             lk  [NCH];
   logic [NCH-1:0] mclk, mtick;
   logic           mclklk;

   clkdiv_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_HP(DHP)) dut (
      .clksrc (clksrc),
      .rstn   (rstn),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_hp  (wr_hp),
      .clk    (clk),
      .tick   (tick),
      .clklk  (clklk)
   );

   always #5 clksrc = ~clksrc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit all_lk;
      if (!rstn) begin
         n      = 0;
         mclk   = '0;
         mtick  = '0;
         mclklk = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            hp[c]  = DHP;
            nxt[c] = DHP;
            php[c] = 0;
            pv[c]  = 1'b0;
            lk[c]  = (DHP == 0);
         end
      end else begin
         n++;
         all_lk = 1'b1;
         for (int c = 0; c < NCH; c++) all_lk &= lk[c] & !pv[c];
         for (int c = 0; c < NCH; c++) begin
            mtick[c] = 1'b0;
            if (hp[c] == 0) begin
               if (pv[c]) begin
                  hp[c]  = php[c];
                  pv[c]  = 1'b0;
                  nxt[c] = n + hp[c];
                  lk[c]  = (hp[c] == 0);
               end
            end else if (n == nxt[c]) begin
               if (pv[c] && php[c] == 0) begin
                  mclk[c] = 1'b0;
                  hp[c]   = 0;
                  pv[c]   = 1'b0;
                  lk[c]   = 1'b1;
               end else begin
                  mclk[c]  = ~mclk[c];
                  mtick[c] = mclk[c];
                  lk[c]    = 1'b1;
                  if (pv[c]) begin
                     hp[c] = php[c];
                     pv[c] = 1'b0;
                     lk[c] = 1'b0;
                  end
                  nxt[c] = n + hp[c];
               end
            end
            if (wr_en && int'(wr_ch) == c) begin
               php[c] = int'(wr_hp);
               pv[c]  = 1'b1;
            end
         end
         mclklk = all_lk;
      end
   endtask

   task automatic step();
      @(posedge clksrc);
      model_edge();
      #1;
      check("clk", 32'(clk), 32'(mclk));
      check("tick", 32'(tick), TICK_ON ? 32'(mtick) : 32'd0);
      check("clklk", 32'(clklk), 32'(mclklk));
   endtask

   task automatic run(input int k);
      for (int j = 0; j < k; j++) step();
   endtask

   task automatic write(input int ch, input int val);
      wr_en = 1'b1;
      wr_ch = 4'(ch);
      wr_hp = WIDTH'(val);
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      step();
      step();
      check("rst_clk", 32'(clk), 32'd0);
      check("rst_clklk", 32'(clklk), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);

      rstn = 1'b1;
      for (int k = 0; k < 13; k++) begin
         step();
         if (n == 4) check("rise_e4", 32'(clk), 32'd3);
         if (n == 5) check("lock_e5", 32'(clklk), 32'd1);
         if (n == 8) check("fall_e8", 32'(clk), 32'd0);
      end

      write(0, 2);
      for (int k = 0; k < 8; k++) begin
         step();
         if (n == 15) check("unlock_after_wr", 32'(clklk), 32'd0);
         if (n == 18) check("ch0_new_rise", 32'(clk[0]), 32'd1);
         if (n == 19) check("relock", 32'(clklk), 32'd1);
      end

      write(1, 0);
      run(14);
      write(1, 3);
      run(14);

      for (int k = 0; k < 4 && nxt[0] != n + 1; k++) step();
      write(0, 6);
      write(0, 1);
      run(12);

      write(3, 7);
      for (int k = 0; k < 3; k++) begin
         step();
         check("badch_lock", 32'(clklk), 32'd1);
      end

      write(0, 5);
      rstn = 1'b0;
      step();
      check("midrst_clk", 32'(clk), 32'd0);
      check("midrst_clklk", 32'(clklk), 32'd0);
      rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (n == 4) check("rst_resume_rise", 32'(clk), 32'd3);
      end

      for (int k = 0; k < 800; k++) begin
         rstn  = ($urandom_range(0, 149) != 0);
         wr_en = ($urandom_range(0, 3) == 0);
         wr_ch = 4'($urandom_range(0, 3));
         wr_hp = WIDTH'($urandom_range(0, 5));
         step();
      end
      rstn  = 1'b1;
      wr_en = 1'b0;
      run(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
